// File: rtl/secure_load_unit.sv
`default_nettype none
// ============================================================================
// Module      : secure_load_unit
// Description : Key-checked memory-to-register load engine. Reads one
//               encrypted word, compares the stored key against the key
//               presented with the request and, on a match (or for an
//               unprotected word with stored key 0), writes the word XORed
//               with the duplicated request key to the register file.
//               Optional lockout after three consecutive key faults is
//               compiled in with macro SEC_LOAD_LOCKOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module secure_load_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_mem_addr,
    input  logic [ADDR_W-1:0] req_reg_addr,
    input  logic [15:0]       req_key,
    output logic              mem_renable,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [15:0]       mem_key,
    output logic              reg_wenable,
    output logic [ADDR_W-1:0] reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              done,
    output logic              fault,
    output logic              busy,
    output logic              locked
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_WRITE = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    // A stored key of zero marks an unprotected word that any key may read.
    localparam logic [15:0] c_OPEN_KEY = 16'h0000;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_reg_addr;
    logic [15:0]         r_key;
    logic [DATA_W-1:0]   r_data;
    logic [15:0]         r_mem_key;

    logic                r_mem_renable;
    logic [ADDR_W-1:0]   r_mem_raddr;
    logic                r_reg_wenable;
    logic [ADDR_W-1:0]   r_reg_waddr;
    logic [DATA_W-1:0]   r_reg_wdata;
    logic                r_done;
    logic                r_fault;

    logic                w_locked;
    logic                w_accept;
    logic                w_key_ok;
    logic [DATA_W-1:0]   w_mask;

    assign w_key_ok = (r_mem_key == r_key) || (r_mem_key == c_OPEN_KEY);
    assign w_mask   = DATA_W'({r_key, r_key});
    assign w_accept = req_valid && req_ready;

    // Main load sequencer; every strobe and its address/data are registered
    // here and default back to zero so they are only non-zero with the strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_reg_addr    <= '0;
            r_key         <= '0;
            r_data        <= '0;
            r_mem_key     <= '0;
            r_mem_renable <= 1'b0;
            r_mem_raddr   <= '0;
            r_reg_wenable <= 1'b0;
            r_reg_waddr   <= '0;
            r_reg_wdata   <= '0;
            r_done        <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_mem_renable <= 1'b0;
            r_mem_raddr   <= '0;
            r_reg_wenable <= 1'b0;
            r_reg_waddr   <= '0;
            r_reg_wdata   <= '0;
            r_done        <= 1'b0;
            r_fault       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_reg_addr    <= req_reg_addr;
                        r_key         <= req_key;
                        r_mem_renable <= 1'b1;
                        r_mem_raddr   <= req_mem_addr;
                        r_state       <= S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Memory returns data and key one cycle after the strobe.
                    r_data    <= mem_rdata;
                    r_mem_key <= mem_key;
                    r_state   <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_key_ok) begin
                        r_reg_wenable <= 1'b1;
                        r_reg_waddr   <= r_reg_addr;
                        r_reg_wdata   <= r_data ^ w_mask;
                        r_done        <= 1'b1;
                        r_state       <= S_WRITE;
                    end else begin
                        r_fault <= 1'b1;
                        r_state <= S_FAULT;
                    end
                end
                S_WRITE, S_FAULT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SEC_LOAD_LOCKOUT_EN
    logic [1:0] r_fault_cnt;
    logic       r_locked;

    // Count consecutive key faults; the third one locks the unit until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fault_cnt <= 2'd0;
            r_locked    <= 1'b0;
        end else begin
            if (r_state == S_CHECK) begin
                if (w_key_ok) begin
                    r_fault_cnt <= 2'd0;
                end else if (r_fault_cnt != 2'd3) begin
                    r_fault_cnt <= r_fault_cnt + 2'd1;
                end
            end
            if ((r_state == S_FAULT) && (r_fault_cnt == 2'd3)) begin
                r_locked <= 1'b1;
            end
        end
    end

    assign w_locked = r_locked;
`else
    assign w_locked = 1'b0;
`endif

    // Ready and busy are gated by rst_n so they read 0 for the whole reset.
    assign req_ready   = rst_n && (r_state == S_IDLE) && !w_locked;
    assign busy        = rst_n && (r_state != S_IDLE);
    assign locked      = w_locked;
    assign mem_renable = r_mem_renable;
    assign mem_raddr   = r_mem_raddr;
    assign reg_wenable = r_reg_wenable;
    assign reg_waddr   = r_reg_waddr;
    assign reg_wdata   = r_reg_wdata;
    assign done        = r_done;
    assign fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_secure_load_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_secure_load_unit
// Description : Self-checking bench for secure_load_unit. A cycle-indexed
//               reference model predicts every output each cycle of a load;
//               expectations for the lockout feature follow macro
//               SEC_LOAD_LOCKOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_secure_load_unit;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;

`ifdef SEC_LOAD_LOCKOUT_EN
    localparam bit c_LOCK_EN = 1'b1;
`else
    localparam bit c_LOCK_EN = 1'b0;
`endif

    typedef logic [58:0] ovec_t;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_mem_addr;
    logic [ADDR_W-1:0] req_reg_addr;
    logic [15:0]       req_key;
    logic              mem_renable;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic [15:0]       mem_key;
    logic              reg_wenable;
    logic [ADDR_W-1:0] reg_waddr;
    logic [DATA_W-1:0] reg_wdata;
    logic              done;
    logic              fault;
    logic              busy;
    logic              locked;

    int   total;
    int   bad;
    int   model_faults;
    logic model_locked;

    secure_load_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_mem_addr (req_mem_addr),
        .req_reg_addr (req_reg_addr),
        .req_key      (req_key),
        .mem_renable  (mem_renable),
        .mem_raddr    (mem_raddr),
        .mem_rdata    (mem_rdata),
        .mem_key      (mem_key),
        .reg_wenable  (reg_wenable),
        .reg_waddr    (reg_waddr),
        .reg_wdata    (reg_wdata),
        .done         (done),
        .fault        (fault),
        .busy         (busy),
        .locked       (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ovec_t pk(input logic rdy, input logic ren, input logic [9:0] ra,
                                 input logic wen, input logic [9:0] wa, input logic [31:0] wd,
                                 input logic dn, input logic ft, input logic bz, input logic lk);
        return {rdy, ren, ra, wen, wa, wd, dn, ft, bz, lk};
    endfunction

    function automatic ovec_t observed();
        return pk(req_ready, mem_renable, mem_raddr, reg_wenable, reg_waddr, reg_wdata,
                  done, fault, busy, locked);
    endfunction

    // Reference behaviour of one load, checked cycle by cycle from acceptance (c=0)
    // to the first idle cycle after done/fault (c=5).
    task automatic run_load(input string nm, input logic [9:0] ma, input logic [9:0] ra,
                            input logic [15:0] key, input logic [31:0] data, input logic [15:0] mk);
        bit          pass;
        logic [31:0] wd;
        ovec_t       e;
        pass = (mk == key) || (mk == 16'h0000);
        wd   = data ^ {key, key};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            case (c)
                0: e = pk(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, model_locked);
                1: e = pk(1'b0, 1'b1, ma, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, model_locked);
                2, 3: e = pk(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, model_locked);
                4: e = pass ? pk(1'b0, 1'b0, '0, 1'b1, ra, wd, 1'b1, 1'b0, 1'b1, model_locked)
                            : pk(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, model_locked);
                default: begin
                    if (pass) begin
                        model_faults = 0;
                    end else begin
                        model_faults++;
                        if (c_LOCK_EN && model_faults >= 3) model_locked = 1'b1;
                    end
                    e = pk(!model_locked, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, model_locked);
                end
            endcase
            total++;
            if (observed() !== e) begin
                bad++;
                $display("FAIL %s c%0d: got %h want %h", nm, c, observed(), e);
            end
            case (c)
                0: begin
                    req_valid = 1'b1; req_mem_addr = ma; req_reg_addr = ra; req_key = key;
                end
                1: begin
                    req_valid = 1'b0; req_mem_addr = 10'($urandom); req_reg_addr = 10'($urandom);
                    req_key = 16'($urandom); mem_rdata = data; mem_key = mk;
                end
                3: begin
                    mem_rdata = $urandom; mem_key = 16'($urandom);
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        ovec_t e;
        @(negedge clk);
        rst_n = 1'b0; req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        e = '0;
        total++;
        if (observed() !== e) begin
            bad++; $display("FAIL reset_hold: got %h want %h", observed(), e);
        end
        rst_n = 1'b1;
        model_faults = 0; model_locked = 1'b0;
        #1;
        e = pk(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (observed() !== e) begin
            bad++; $display("FAIL reset_release: got %h want %h", observed(), e);
        end
    endtask

    task automatic test_key_match();
        run_load("key_match", 10'h155, 10'h2AA, 16'hA5A5, 32'h1234_5678, 16'hA5A5);
    endtask

    task automatic test_key_mismatch();
        run_load("key_mismatch", 10'h003, 10'h3FF, 16'h0001, 32'hDEAD_BEEF, 16'h0002);
    endtask

    task automatic test_unprotected();
        run_load("unprotected", 10'h3FF, 10'h000, 16'hFFFF, 32'hFFFF_0000, 16'h0000);
    endtask

    // Faults are never consecutive here, so the lockout never triggers.
    task automatic test_random();
        logic [15:0] k;
        logic [15:0] mk;
        for (int i = 0; i < 9; i++) begin
            k = 16'($urandom);
            case (i % 3)
                0: mk = k;
                1: mk = 16'h0000;
                default: mk = k ^ 16'($urandom_range(1, 65535));
            endcase
            run_load("random", 10'($urandom), 10'($urandom), k, $urandom, mk);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  ma_a, ra_a, ma_b, ra_b;
        logic [15:0] k_a, k_b;
        logic [31:0] d_a, d_b;
        logic        rdy, ren, wen;
        logic [9:0]  ra_e, wa_e;
        logic [31:0] wd_e;
        int          ren_cnt;
        ovec_t       e;
        ma_a = 10'($urandom); ra_a = 10'($urandom); k_a = 16'($urandom); d_a = $urandom;
        ma_b = 10'($urandom); ra_b = 10'($urandom); k_b = 16'($urandom); d_b = $urandom;
        ren_cnt = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            rdy  = (c == 0) || (c == 5) || (c == 10);
            ren  = (c == 1) || (c == 6);
            wen  = (c == 4) || (c == 9);
            ra_e = (c == 1) ? ma_a : (c == 6) ? ma_b : 10'h000;
            wa_e = (c == 4) ? ra_a : (c == 9) ? ra_b : 10'h000;
            wd_e = (c == 4) ? (d_a ^ {k_a, k_a}) : (c == 9) ? (d_b ^ {k_b, k_b}) : 32'h0;
            e = pk(rdy, ren, ra_e, wen, wa_e, wd_e, wen, 1'b0, !rdy, 1'b0);
            if (mem_renable === 1'b1) ren_cnt++;
            total++;
            if (observed() !== e) begin
                bad++; $display("FAIL back_to_back c%0d: got %h want %h", c, observed(), e);
            end
            case (c)
                0: begin
                    req_valid = 1'b1; req_mem_addr = ma_a; req_reg_addr = ra_a; req_key = k_a;
                end
                1: begin
                    req_mem_addr = ma_b; req_reg_addr = ra_b; req_key = k_b;
                    mem_rdata = d_a; mem_key = 16'h0000;
                end
                3, 8: begin
                    mem_rdata = $urandom; mem_key = 16'($urandom);
                end
                6: begin
                    req_valid = 1'b0; mem_rdata = d_b; mem_key = 16'h0000;
                end
                default: ;
            endcase
        end
        total++;
        if (ren_cnt != 2) begin
            bad++; $display("FAIL back_to_back_renable_count: got %0d want 2", ren_cnt);
        end
    endtask

    task automatic test_reset_in_wait();
        ovec_t e;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            case (c)
                0: e = pk(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
                1: e = pk(1'b0, 1'b1, 10'h0A5, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
                2: e = pk(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
                default: e = '0;
            endcase
            total++;
            if (observed() !== e) begin
                bad++; $display("FAIL reset_in_wait c%0d: got %h want %h", c, observed(), e);
            end
            case (c)
                0: begin
                    req_valid = 1'b1; req_mem_addr = 10'h0A5; req_reg_addr = 10'h05A; req_key = 16'h1234;
                end
                1: begin
                    req_valid = 1'b0; mem_rdata = 32'hCAFE_F00D; mem_key = 16'h1234;
                end
                2: rst_n = 1'b0;
                4: rst_n = 1'b1;
                default: ;
            endcase
        end
        model_faults = 0; model_locked = 1'b0;
        #1;
        e = pk(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (observed() !== e) begin
            bad++; $display("FAIL reset_in_wait_release: got %h want %h", observed(), e);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (observed() !== e) begin
                bad++; $display("FAIL reset_in_wait_after c%0d: got %h want %h", c, observed(), e);
            end
        end
    endtask

    task automatic test_lockout();
        ovec_t e;
        test_reset();
        for (int i = 0; i < 3; i++) begin
            run_load("lockout_fault", 10'(i), 10'(i + 16), 16'h0001, $urandom, 16'h0002);
        end
        e = pk(!model_locked, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, model_locked);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (observed() !== e) begin
                bad++; $display("FAIL lockout_idle c%0d: got %h want %h", c, observed(), e);
            end
        end
        if (model_locked) begin
            req_valid = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                total++;
                if (observed() !== e) begin
                    bad++; $display("FAIL lockout_ignored c%0d: got %h want %h", c, observed(), e);
                end
            end
            req_valid = 1'b0;
        end
    endtask

    initial begin
        total = 0; bad = 0; model_faults = 0; model_locked = 1'b0;
        rst_n = 1'b0; req_valid = 1'b0; req_mem_addr = '0; req_reg_addr = '0;
        req_key = '0; mem_rdata = '0; mem_key = '0;
        test_reset();
        test_key_match();
        test_key_mismatch();
        test_unprotected();
        test_random();
        test_back_to_back();
        test_reset_in_wait();
        test_lockout();
        test_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/secure_load_unit.md
SECURE_LOAD_UNIT -- requirements
Module: secure_load_unit

Interface
REQ-001 Parameter: DATA_W, default 32, data word width (also the decrypt mask width, two copies of the key).
REQ-002 Parameter: ADDR_W, default 10, memory and register address width.
REQ-003 Ports, clock and reset first:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- req_valid  in  1  load request present.
- req_ready  out  1  unit accepts a request this cycle.
- req_mem_addr  in  ADDR_W  source memory address.
- req_reg_addr  in  ADDR_W  destination register address.
- req_key  in  16  key presented by the register side.
- mem_renable  out  1  memory read strobe.
- mem_raddr  out  ADDR_W  memory read address.
- mem_rdata  in  DATA_W  encrypted word; valid the cycle after mem_renable.
- mem_key  in  16  key stored for that word; valid with mem_rdata.
- reg_wenable  out  1  register write strobe.
- reg_waddr  out  ADDR_W  register write address.
- reg_wdata  out  DATA_W  decrypted word.
- done  out  1  one-cycle pulse: load completed.
- fault  out  1  one-cycle pulse: key mismatch, no write performed.
- busy  out  1  high in every state except IDLE.
- locked  out  1  lockout active; tied 0 when the lockout feature is compiled out.

Function
REQ-004 FSM states: IDLE, READ, WAIT, CHECK, WRITE, FAULT.
REQ-005 req_ready = 1 only in IDLE with locked = 0.
REQ-006 Request accepted on cycle N when req_valid and req_ready; req_mem_addr, req_reg_addr and req_key are latched on that edge; next state READ.
REQ-007 READ, cycle N+1: mem_renable = 1 and mem_raddr = latched address; next state WAIT.
REQ-008 WAIT, cycle N+2: mem_renable = 0; mem_rdata and mem_key are captured into internal registers at the end of this cycle; next state CHECK.
REQ-009 CHECK, cycle N+3: key passes when mem_key == req_key, or when mem_key == 16'h0000 (unprotected word, any key passes); pass goes to WRITE, otherwise FAULT.
REQ-010 WRITE, cycle N+4:
- reg_wenable = 1, done = 1;
- reg_waddr = latched register address;
- reg_wdata = captured data XOR {req_key, req_key};
- next state IDLE.
REQ-011 FAULT, cycle N+4: fault = 1 and reg_wenable = 0; next state IDLE.
REQ-012 Latency: accept to done/fault is 4 cycles; maximum throughput is one request per 5 cycles.
REQ-013 mem_raddr, reg_waddr and reg_wdata are 0 whenever their strobe is low.
REQ-014 Request inputs are ignored while busy; req_valid held high is not a second request.
REQ-015 done and fault are never high in the same cycle.
REQ-016 Addresses pass through unmodified: no increment and no wrap.

Reset
REQ-017 rst_n low at a clock edge forces IDLE, clears all latched and captured registers, and clears the fault counter and lock.
REQ-018 Output values during reset: req_ready = 0 while rst_n is low, then 1 on the first cycle after release; every other output is 0.
REQ-019 Reset asserted mid-operation aborts the load: no reg_wenable, done or fault is produced for that request.

Configuration
REQ-020 Macro SEC_LOAD_LOCKOUT_EN.
REQ-021 With SEC_LOAD_LOCKOUT_EN defined:
- a 2-bit counter increments on each FAULT and clears on each WRITE;
- when a FAULT takes the count to 3, locked = 1 from the following cycle until reset;
- while locked, req_ready = 0.
REQ-022 Without SEC_LOAD_LOCKOUT_EN: no counter exists, locked is tied 0, and faults never block requests.

Verification
REQ-023 Key match: req_key=16'hA5A5, mem_key=16'hA5A5, mem_rdata=32'h1234_5678 -> cycle N+4 reg_wenable=1, reg_wdata=32'hB791_F3DD, done=1.
REQ-024 Key mismatch: req_key=16'h0001, mem_key=16'h0002 -> fault=1 at N+4, reg_wenable never 1, req_ready=1 at N+5.
REQ-025 Unprotected word: mem_key=16'h0000, req_key=16'hFFFF, mem_rdata=32'hFFFF_0000 -> reg_wdata=32'h0000_FFFF, done=1.
REQ-026 Back-to-back: req_valid held high with two requests -> second request accepted at N+5, never earlier, and mem_renable pulses exactly once per request.
REQ-027 Reset in WAIT: rst_n=0 at N+2 -> no reg_wenable, done or fault; all outputs 0 while rst_n=0; req_ready=1 on the first cycle after rst_n returns high.
REQ-028 With SEC_LOAD_LOCKOUT_EN: three consecutive mismatches -> locked=1 and req_ready=0 until reset; the same stimulus without the macro -> locked=0 and req_ready=1 after each fault.
